// File: rtl/fdtd_mem_xfer.sv
// fdtd_mem_xfer: moves FDTD field words between data memory and the Hy/Ez/src line buffers.
// Build option FDTD_XFER_PERF_CNT_EN adds a saturating data-memory stall counter.
module fdtd_mem_xfer #(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int DM_ADDR_WIDTH     = 32
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         cmd_start_i,
  input  logic [1:0]                   cmd_type_i,
  input  logic                         cmd_field_i,
  input  logic [DM_ADDR_WIDTH-1:0]     cmd_base_i,
  input  logic [BUFFER_ADDR_WIDTH:0]   cmd_len_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         dm_req_o,
  output logic                         dm_we_o,
  output logic [DM_ADDR_WIDTH-1:0]     dm_addr_o,
  output logic [FDTD_DATA_WIDTH-1:0]   dm_wdata_o,
  input  logic                         dm_gnt_i,
  input  logic                         dm_rvalid_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   dm_rdata_i,
  output logic                         buffer_Hy_start_o,
  output logic                         buffer_Ez_start_o,
  output logic                         buffer_src_start_o,
  output logic                         buffer_Hy_end_o,
  output logic                         buffer_Ez_end_o,
  output logic                         buffer_src_end_o,
  output logic                         wrtvalid_Hy_old_o,
  output logic                         wrtvalid_Ez_old_o,
  output logic [FDTD_DATA_WIDTH-1:0]   Hy_old_o,
  output logic [FDTD_DATA_WIDTH-1:0]   Ez_old_o,
  output logic                         mem_rd_Hy_en_o,
  output logic                         mem_rd_Ez_en_o,
  output logic                         wrtvalid_sgl_o,
  output logic                         mem_rd_end_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   Hy_n_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   Ez_n_i,
  output logic [15:0]                  perf_stall_cnt_o,
  output logic [3:0]                   dbg_state_o
);

  localparam int IW = BUFFER_ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, LD_START, LD_WAIT, LD_REQ, LD_RESP, LD_END,
    ST_SEL, ST_WAIT, ST_RD, ST_CAP, ST_WREQ, ST_END, DONE
  } state_t;

  state_t                       state;
  logic [1:0]                   type_q;
  logic                         field_q;
  logic [DM_ADDR_WIDTH-1:0]     base_q;
  logic [IW-1:0]                len_q;
  logic [IW-1:0]                idx;
  logic [IW-1:0]                idx_inc;
  logic                         wait_cnt;
  logic                         end_phase;
  logic [FDTD_DATA_WIDTH-1:0]   old_q;
  logic [DM_ADDR_WIDTH-1:0]     addr_cur;
  logic [DM_ADDR_WIDTH-1:0]     addr_inc;

  assign idx_inc  = idx + {{(IW-1){1'b0}}, 1'b1};
  assign addr_cur = base_q + (DM_ADDR_WIDTH'(idx) << 2);
  assign addr_inc = base_q + (DM_ADDR_WIDTH'(idx_inc) << 2);

  assign Hy_old_o    = old_q;
  assign Ez_old_o    = old_q;
  assign dbg_state_o = state;

  // Data-memory handshake: dm_req_o with dm_we_o/dm_addr_o/dm_wdata_o is held stable until a
  // cycle with dm_gnt_i=1; read data arrives on a later dm_rvalid_i cycle, one read outstanding.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state              <= IDLE;
      type_q             <= '0;
      field_q            <= 1'b0;
      base_q             <= '0;
      len_q              <= '0;
      idx                <= '0;
      wait_cnt           <= 1'b0;
      end_phase          <= 1'b0;
      old_q              <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      dm_req_o           <= 1'b0;
      dm_we_o            <= 1'b0;
      dm_addr_o          <= '0;
      dm_wdata_o         <= '0;
      buffer_Hy_start_o  <= 1'b0;
      buffer_Ez_start_o  <= 1'b0;
      buffer_src_start_o <= 1'b0;
      buffer_Hy_end_o    <= 1'b0;
      buffer_Ez_end_o    <= 1'b0;
      buffer_src_end_o   <= 1'b0;
      wrtvalid_Hy_old_o  <= 1'b0;
      wrtvalid_Ez_old_o  <= 1'b0;
      mem_rd_Hy_en_o     <= 1'b0;
      mem_rd_Ez_en_o     <= 1'b0;
      wrtvalid_sgl_o     <= 1'b0;
      mem_rd_end_o       <= 1'b0;
    end else begin
      buffer_Hy_start_o  <= 1'b0;
      buffer_Ez_start_o  <= 1'b0;
      buffer_src_start_o <= 1'b0;
      buffer_Hy_end_o    <= 1'b0;
      buffer_Ez_end_o    <= 1'b0;
      buffer_src_end_o   <= 1'b0;
      wrtvalid_Hy_old_o  <= 1'b0;
      wrtvalid_Ez_old_o  <= 1'b0;
      mem_rd_Hy_en_o     <= 1'b0;
      mem_rd_Ez_en_o     <= 1'b0;
      wrtvalid_sgl_o     <= 1'b0;
      mem_rd_end_o       <= 1'b0;
      done_o             <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start_i) begin
            type_q  <= cmd_type_i;
            field_q <= cmd_field_i;
            base_q  <= cmd_base_i;
            len_q   <= cmd_len_i;
            idx     <= '0;
            busy_o  <= 1'b1;
            if (cmd_len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (cmd_type_i == 2'd3) begin
              state          <= ST_SEL;
              mem_rd_Hy_en_o <= ~cmd_field_i;
              mem_rd_Ez_en_o <= cmd_field_i;
            end else begin
              state              <= LD_START;
              buffer_Hy_start_o  <= (cmd_type_i == 2'd0);
              buffer_Ez_start_o  <= (cmd_type_i == 2'd1);
              buffer_src_start_o <= (cmd_type_i == 2'd2);
            end
          end
        end
        LD_START: begin
          state    <= LD_WAIT;
          wait_cnt <= 1'b0;
        end
        // Two idle cycles let the buffer finish synchronising its start pulse.
        LD_WAIT: begin
          if (wait_cnt) begin
            state     <= LD_REQ;
            dm_req_o  <= 1'b1;
            dm_we_o   <= 1'b0;
            dm_addr_o <= addr_cur;
          end else begin
            wait_cnt <= 1'b1;
          end
        end
        LD_REQ: begin
          if (dm_gnt_i) begin
            dm_req_o <= 1'b0;
            state    <= LD_RESP;
          end
        end
        LD_RESP: begin
          if (dm_rvalid_i) begin
            old_q             <= dm_rdata_i;
            wrtvalid_Hy_old_o <= (type_q == 2'd0);
            wrtvalid_Ez_old_o <= (type_q != 2'd0);
            idx               <= idx_inc;
            if (idx_inc == len_q) begin
              state <= LD_END;
            end else begin
              state     <= LD_REQ;
              dm_req_o  <= 1'b1;
              dm_addr_o <= addr_inc;
            end
          end
        end
        // First LD_END cycle carries the last write strobe; the end pulse follows it.
        LD_END: begin
          if (!end_phase) begin
            end_phase        <= 1'b1;
            buffer_Hy_end_o  <= (type_q == 2'd0);
            buffer_Ez_end_o  <= (type_q == 2'd1);
            buffer_src_end_o <= (type_q == 2'd2);
          end else begin
            end_phase <= 1'b0;
            state     <= DONE;
            done_o    <= 1'b1;
          end
        end
        ST_SEL:  state <= ST_WAIT;
        ST_WAIT: begin
          state          <= ST_RD;
          wrtvalid_sgl_o <= 1'b1;
        end
        ST_RD:   state <= ST_CAP;
        ST_CAP: begin
          dm_wdata_o <= field_q ? Ez_n_i : Hy_n_i;
          dm_req_o   <= 1'b1;
          dm_we_o    <= 1'b1;
          dm_addr_o  <= addr_cur;
          state      <= ST_WREQ;
        end
        ST_WREQ: begin
          if (dm_gnt_i) begin
            dm_req_o <= 1'b0;
            dm_we_o  <= 1'b0;
            idx      <= idx_inc;
            if (idx_inc == len_q) begin
              state        <= ST_END;
              mem_rd_end_o <= 1'b1;
            end else begin
              state          <= ST_RD;
              wrtvalid_sgl_o <= 1'b1;
            end
          end
        end
        ST_END: begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FDTD_XFER_PERF_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
    end else if (state == IDLE && cmd_start_i) begin
      stall_cnt <= '0;
    end else if (dm_req_o && !dm_gnt_i && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_fdtd_mem_xfer.sv
// Bench for fdtd_mem_xfer: memory/buffer responders, event scoreboard against a
// command-level reference model, directed cases plus a randomized command stream.
module tb_fdtd_mem_xfer;
  localparam int DW = 32;
  localparam int BAW = 6;
  localparam int AW = 32;
  localparam int IW = BAW + 1;
  localparam int EW = 68;
  localparam int CW = 200;

  localparam logic [3:0] K_START_HY = 4'd1, K_START_EZ = 4'd2, K_START_SRC = 4'd3;
  localparam logic [3:0] K_RD = 4'd4, K_WV_HY = 4'd5, K_WV_EZ = 4'd6;
  localparam logic [3:0] K_END_HY = 4'd7, K_END_EZ = 4'd8, K_END_SRC = 4'd9;
  localparam logic [3:0] K_SEL_HY = 4'd10, K_SEL_EZ = 4'd11, K_SGL = 4'd12;
  localparam logic [3:0] K_WR = 4'd13, K_RD_END = 4'd14, K_DONE = 4'd15;

`ifdef FDTD_XFER_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic            cmd_start_i = 1'b0;
  logic [1:0]      cmd_type_i = '0;
  logic            cmd_field_i = 1'b0;
  logic [AW-1:0]   cmd_base_i = '0;
  logic [IW-1:0]   cmd_len_i = '0;
  logic            dm_gnt_i = 1'b0;
  logic            dm_rvalid_i = 1'b0;
  logic [DW-1:0]   dm_rdata_i = '0;
  logic [DW-1:0]   Hy_n_i = '0;
  logic [DW-1:0]   Ez_n_i = '0;
  logic            busy_o, done_o, dm_req_o, dm_we_o;
  logic [AW-1:0]   dm_addr_o;
  logic [DW-1:0]   dm_wdata_o;
  logic            buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o;
  logic            buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o;
  logic            wrtvalid_Hy_old_o, wrtvalid_Ez_old_o;
  logic [DW-1:0]   Hy_old_o, Ez_old_o;
  logic            mem_rd_Hy_en_o, mem_rd_Ez_en_o, wrtvalid_sgl_o, mem_rd_end_o;
  logic [15:0]     perf_stall_cnt_o;
  logic [3:0]      dbg_state_o;

  fdtd_mem_xfer #(
    .FDTD_DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(BAW), .DM_ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_start_i(cmd_start_i), .cmd_type_i(cmd_type_i), .cmd_field_i(cmd_field_i),
    .cmd_base_i(cmd_base_i), .cmd_len_i(cmd_len_i),
    .busy_o(busy_o), .done_o(done_o),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .buffer_Hy_start_o(buffer_Hy_start_o), .buffer_Ez_start_o(buffer_Ez_start_o),
    .buffer_src_start_o(buffer_src_start_o),
    .buffer_Hy_end_o(buffer_Hy_end_o), .buffer_Ez_end_o(buffer_Ez_end_o),
    .buffer_src_end_o(buffer_src_end_o),
    .wrtvalid_Hy_old_o(wrtvalid_Hy_old_o), .wrtvalid_Ez_old_o(wrtvalid_Ez_old_o),
    .Hy_old_o(Hy_old_o), .Ez_old_o(Ez_old_o),
    .mem_rd_Hy_en_o(mem_rd_Hy_en_o), .mem_rd_Ez_en_o(mem_rd_Ez_en_o),
    .wrtvalid_sgl_o(wrtvalid_sgl_o), .mem_rd_end_o(mem_rd_end_o),
    .Hy_n_i(Hy_n_i), .Ez_n_i(Ez_n_i),
    .perf_stall_cnt_o(perf_stall_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] buf_hy [64];
  logic [31:0] buf_ez [64];
  int fixed_stall = 0;
  int stall_tally = 0;
  int wv_seen = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic push(input logic [3:0] k, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({k, a, d});
  endtask

  // Reference model: the full event trace a command must produce, in order.
  task automatic model_cmd(input logic [1:0] t, input logic f, input logic [31:0] base, input int len);
    logic [31:0] a;
    logic [31:0] d;
    if (len == 0) begin
      push(K_DONE, 0, 0);
    end else if (t == 2'd3) begin
      push(f ? K_SEL_EZ : K_SEL_HY, 0, 0);
      for (int i = 0; i < len; i++) begin
        a = base + 32'(4 * i);
        d = f ? buf_ez[i] : buf_hy[i];
        push(K_SGL, 0, 0);
        push(K_WR, a, d);
        mem[a] = d;
      end
      push(K_RD_END, 0, 0);
      push(K_DONE, 0, 0);
    end else begin
      push(t == 2'd0 ? K_START_HY : (t == 2'd1 ? K_START_EZ : K_START_SRC), 0, 0);
      for (int i = 0; i < len; i++) begin
        a = base + 32'(4 * i);
        push(K_RD, a, 0);
        push(t == 2'd0 ? K_WV_HY : K_WV_EZ, 0, rd_mem(a));
      end
      push(t == 2'd0 ? K_END_HY : (t == 2'd1 ? K_END_EZ : K_END_SRC), 0, 0);
      push(K_DONE, 0, 0);
    end
  endtask

  // driver tasks
  task automatic fill_bufs();
    for (int i = 0; i < 64; i++) begin
      buf_hy[i] = $urandom;
      buf_ez[i] = $urandom;
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic f, input logic [31:0] base, input int len);
    model_cmd(t, f, base, len);
    @(posedge CLK); #1;
    stall_tally = 0;
    cmd_start_i = 1'b1;
    cmd_type_i  = t;
    cmd_field_i = f;
    cmd_base_i  = base;
    cmd_len_i   = IW'(len);
    @(posedge CLK); #1;
    cmd_start_i = 1'b0;
    cmd_type_i  = 2'($urandom);
    cmd_field_i = 1'($urandom);
    cmd_base_i  = $urandom;
    cmd_len_i   = IW'($urandom);
    check("busy_after_accept", busy_o, 1);
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (c < budget) begin
      @(negedge CLK); #2;
      if (done_o) break;
      c++;
    end
    if (c >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: actual no done_o after %0d cycles required done_o", budget);
    end
    @(negedge CLK); #2;
    check("busy_after_done", busy_o, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {busy_o, done_o, dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
                 buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o,
                 buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o,
                 wrtvalid_Hy_old_o, wrtvalid_Ez_old_o, Hy_old_o, Ez_old_o,
                 mem_rd_Hy_en_o, mem_rd_Ez_en_o, wrtvalid_sgl_o, mem_rd_end_o,
                 perf_stall_cnt_o, dbg_state_o}, 0);
  endtask

  // data-memory responder: grant after a chosen stall, read data after a short delay
  initial begin : dm_responder
    int  stall_left;
    bit  in_req;
    bit  rd_pend;
    int  rd_dly;
    logic [31:0] rd_addr;
    in_req = 0;
    rd_pend = 0;
    stall_left = 0;
    rd_dly = 0;
    rd_addr = '0;
    forever begin
      @(posedge CLK); #1;
      dm_gnt_i = 1'b0;
      dm_rvalid_i = 1'b0;
      dm_rdata_i = $urandom;
      if (!RST_N) begin
        in_req = 0;
        rd_pend = 0;
      end else begin
        if (rd_pend) begin
          rd_dly--;
          if (rd_dly == 0) begin
            dm_rvalid_i = 1'b1;
            dm_rdata_i = rd_mem(rd_addr);
            rd_pend = 0;
          end
        end
        if (dm_req_o) begin
          if (!in_req) begin
            in_req = 1;
            stall_left = (fixed_stall < 0) ? int'($urandom_range(0, 3)) : fixed_stall;
          end
          if (stall_left == 0) begin
            dm_gnt_i = 1'b1;
            in_req = 0;
            if (!dm_we_o) begin
              rd_pend = 1;
              rd_addr = dm_addr_o;
              rd_dly = (fixed_stall < 0) ? int'($urandom_range(1, 3)) : 1;
            end
          end else begin
            stall_left--;
            stall_tally++;
          end
        end
      end
    end
  end

  // line-buffer responder: word appears one cycle after each read strobe, noise otherwise
  initial begin : buf_responder
    bit sgl_seen;
    bit sel_seen;
    int bptr;
    bptr = 0;
    forever begin
      @(negedge CLK);
      sgl_seen = wrtvalid_sgl_o;
      sel_seen = mem_rd_Hy_en_o | mem_rd_Ez_en_o;
      @(posedge CLK); #1;
      if (sel_seen) bptr = 0;
      if (sgl_seen) begin
        Hy_n_i = buf_hy[bptr % 64];
        Ez_n_i = buf_ez[bptr % 64];
        bptr++;
      end else begin
        Hy_n_i = $urandom;
        Ez_n_i = $urandom;
      end
    end
  end

  // monitor: turns DUT output activity into events and pops the expected queue
  task automatic observe(input logic [3:0] k, input logic [31:0] a, input logic [31:0] d);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL event: actual %0h required none", {k, a, d});
    end else begin
      check("event", {k, a, d}, exp_q.pop_front());
    end
  endtask

  initial begin : monitor
    bit prev_stall, prev_we, prev_wv, wv_now, end_now;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    prev_stall = 0;
    prev_wv = 0;
    prev_we = 0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_stall = 0;
        prev_wv = 0;
      end else begin
        wv_now  = wrtvalid_Hy_old_o | wrtvalid_Ez_old_o;
        end_now = buffer_Hy_end_o | buffer_Ez_end_o | buffer_src_end_o;
        if (prev_stall)
          check("req_hold", {dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o},
                {1'b1, prev_we, prev_addr, prev_wdata});
        if (end_now) check("end_gap", {prev_wv, wv_now}, 2'b10);
        if (buffer_Hy_start_o)  observe(K_START_HY, 0, 0);
        if (buffer_Ez_start_o)  observe(K_START_EZ, 0, 0);
        if (buffer_src_start_o) observe(K_START_SRC, 0, 0);
        if (wrtvalid_Hy_old_o) begin observe(K_WV_HY, 0, Hy_old_o); wv_seen++; end
        if (wrtvalid_Ez_old_o) begin observe(K_WV_EZ, 0, Ez_old_o); wv_seen++; end
        if (buffer_Hy_end_o)  observe(K_END_HY, 0, 0);
        if (buffer_Ez_end_o)  observe(K_END_EZ, 0, 0);
        if (buffer_src_end_o) observe(K_END_SRC, 0, 0);
        if (dm_req_o && dm_gnt_i) begin
          if (dm_we_o) observe(K_WR, dm_addr_o, dm_wdata_o);
          else         observe(K_RD, dm_addr_o, 0);
        end
        if (mem_rd_Hy_en_o) observe(K_SEL_HY, 0, 0);
        if (mem_rd_Ez_en_o) observe(K_SEL_EZ, 0, 0);
        if (wrtvalid_sgl_o) observe(K_SGL, 0, 0);
        if (mem_rd_end_o)   observe(K_RD_END, 0, 0);
        if (done_o)         observe(K_DONE, 0, 0);
        prev_stall = dm_req_o && !dm_gnt_i;
        prev_we    = dm_we_o;
        prev_addr  = dm_addr_o;
        prev_wdata = dm_wdata_o;
        prev_wv    = wv_now;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin : main
    int w0, c, len;
    logic [1:0] t;
    logic [31:0] base;
    fill_bufs();
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset_outputs");
    #2 RST_N = 1'b1;

    // load Hy, immediate grant
    fixed_stall = 0;
    issue(2'd0, 1'b0, 32'h0000_1000, 4);
    wait_done(200);

    // full-length src load
    issue(2'd2, 1'b0, 32'h0001_0000, 64);
    wait_done(1000);

    // store Ez with known buffer words
    buf_ez[0] = 32'hA;
    buf_ez[1] = 32'hB;
    buf_ez[2] = 32'hC;
    issue(2'd3, 1'b1, 32'h0000_2000, 3);
    wait_done(200);

    // withheld grants: stall counter per command
    fixed_stall = 5;
    issue(2'd1, 1'b0, 32'h0000_5000, 3);
    wait_done(300);
    check("perf_load_stall", perf_stall_cnt_o, PERF_EN ? 15 : 0);
    fill_bufs();
    issue(2'd3, 1'b0, 32'h0000_5100, 2);
    wait_done(300);
    check("perf_store_stall", perf_stall_cnt_o, PERF_EN ? 10 : 0);

    // reset in the middle of an 8-word load
    fixed_stall = 0;
    w0 = wv_seen;
    issue(2'd0, 1'b0, 32'h0000_3000, 8);
    c = 0;
    while (wv_seen - w0 < 2 && c < 200) begin
      @(negedge CLK); #2;
      c++;
    end
    check("mid_load_progress", (wv_seen - w0) >= 2, 1);
    RST_N = 1'b0;
    #1;
    check_outputs_zero("reset_mid_load");
    exp_q.delete();
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
    issue(2'd0, 1'b0, 32'h0000_4000, 2);
    wait_done(200);

    // zero length completes the cycle after acceptance
    issue(2'd1, 1'b0, 32'h0000_7000, 0);
    check("zero_len_done", done_o, 1);
    wait_done(10);

    // start while busy is ignored
    issue(2'd0, 1'b0, 32'h0000_6000, 4);
    @(posedge CLK); #1;
    cmd_start_i = 1'b1;
    cmd_type_i  = 2'd3;
    cmd_len_i   = IW'(5);
    cmd_base_i  = 32'h0000_9000;
    @(posedge CLK); #1;
    cmd_start_i = 1'b0;
    wait_done(200);

    // randomized command stream, including address wrap-around
    fixed_stall = -1;
    for (int n = 0; n < 25; n++) begin
      fill_bufs();
      t = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 8));
      base = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      issue(t, 1'($urandom), base, len);
      wait_done(3000);
      check("perf_random", perf_stall_cnt_o, PERF_EN ? (stall_tally > 65535 ? 65535 : stall_tally) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
